// File: rtl/mm_read_arbiter_if.sv
// Bundle of requester-side, port-bank-side and response signals for
// mm_read_arbiter. The master modport drives requests and port data, and
// the slave modport is the arbiter itself.
interface mm_read_arbiter_if #(
  parameter int WORD_WIDTH   = 36,
  parameter int ADDR_WIDTH   = 10,
  parameter int INPUT_COUNT  = 4,
  parameter int REQ_COUNT    = 4,
  parameter int REQ_ID_WIDTH = 2
);
  logic [REQ_COUNT-1:0]              req;
  logic [REQ_COUNT*ADDR_WIDTH-1:0]   req_addr;
  logic [REQ_COUNT-1:0]              req_ready;
  logic [INPUT_COUNT*WORD_WIDTH-1:0] in;
  logic [INPUT_COUNT-1:0]            in_valid;
  logic [INPUT_COUNT-1:0]            in_ack;
  logic                              rsp_valid;
  logic [REQ_ID_WIDTH-1:0]           rsp_id;
  logic [WORD_WIDTH-1:0]             rsp_data;
  logic                              rsp_error;
  logic [15:0]                       stall_count;

  modport master (
    output req, req_addr, in, in_valid,
    input  req_ready, in_ack, rsp_valid, rsp_id, rsp_data, rsp_error, stall_count
  );

  modport slave (
    input  req, req_addr, in, in_valid,
    output req_ready, in_ack, rsp_valid, rsp_id, rsp_data, rsp_error, stall_count
  );
endinterface

// File: rtl/mm_read_arbiter.sv
// Round-robin arbiter sharing one memory-mapped read window among
// REQ_COUNT requesters. The window is INPUT_COUNT consecutive word ports
// starting at INPUT_BASE_ADDR, which does not have to be aligned. At most
// one requester is granted per cycle. The granted port is popped in the
// same cycle, and the word comes back on a registered response one cycle
// later.
// Optional: define MM_READ_ARBITER_STALL_COUNT_EN to build a saturating
// counter of cycles where requests are pending but none can be served.
module mm_read_arbiter #(
  parameter int WORD_WIDTH       = 36,
  parameter int ADDR_WIDTH       = 10,
  parameter int INPUT_COUNT      = 4,
  parameter int INPUT_BASE_ADDR  = 1020,
  parameter int INPUT_ADDR_WIDTH = 2,
  parameter int REQ_COUNT        = 4,
  parameter int REQ_ID_WIDTH     = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  mm_read_arbiter_if.slave  bus
);

  // The compare uses one extra bit because base + count can exceed the raw
  // address range (1020 + 4 = 1024 does not fit in 10 bits).
  localparam logic [ADDR_WIDTH:0]   BASE_EXT  = (ADDR_WIDTH+1)'(INPUT_BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   LIMIT_EXT = (ADDR_WIDTH+1)'(INPUT_BASE_ADDR + INPUT_COUNT);
  localparam logic [REQ_ID_WIDTH:0] REQ_COUNT_EXT = (REQ_ID_WIDTH+1)'(REQ_COUNT);
  localparam logic [REQ_ID_WIDTH-1:0] LAST_REQ  = REQ_ID_WIDTH'(REQ_COUNT - 1);

  logic [REQ_COUNT-1:0]        in_range_s;
  logic [REQ_COUNT-1:0]        eligible_s;
  logic [INPUT_ADDR_WIDTH-1:0] index_s [REQ_COUNT];
  logic                        grant_valid_s;
  logic [REQ_ID_WIDTH-1:0]     grant_id_s;

  logic [REQ_ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [REQ_ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
  logic [WORD_WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic                        rsp_error_q, rsp_error_d;

  // Per-requester range check, index translation and eligibility.
  // A requester waiting on an empty port is not eligible, so it does not block the others.
  always_comb begin
    logic [ADDR_WIDTH:0] addr_ext_v;
    logic [ADDR_WIDTH:0] offset_v;
    logic                rng_v;
    in_range_s = '0;
    eligible_s = '0;
    index_s    = '{default: '0};
    for (int r = 0; r < REQ_COUNT; r++) begin
      addr_ext_v    = {1'b0, bus.req_addr[r*ADDR_WIDTH +: ADDR_WIDTH]};
      offset_v      = addr_ext_v - BASE_EXT;
      rng_v         = (addr_ext_v >= BASE_EXT) && (addr_ext_v < LIMIT_EXT);
      index_s[r]    = offset_v[INPUT_ADDR_WIDTH-1:0];
      in_range_s[r] = rng_v;
      if (rng_v) begin
        eligible_s[r] = bus.req[r] & bus.in_valid[offset_v[INPUT_ADDR_WIDTH-1:0]];
      end else begin
        eligible_s[r] = bus.req[r];
      end
    end
  end

  // Round-robin pick: the first eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [REQ_ID_WIDTH:0]   sum_v;
    logic [REQ_ID_WIDTH-1:0] cand_v;
    grant_valid_s = 1'b0;
    grant_id_s    = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      sum_v = {1'b0, rr_ptr_q} + (REQ_ID_WIDTH+1)'(k);
      if (sum_v >= REQ_COUNT_EXT) begin
        sum_v = sum_v - REQ_COUNT_EXT;
      end else begin
        sum_v = sum_v;
      end
      cand_v = sum_v[REQ_ID_WIDTH-1:0];
      if (!grant_valid_s && eligible_s[cand_v]) begin
        grant_valid_s = 1'b1;
        grant_id_s    = cand_v;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Combinational accept and pop pulses. Both are held at zero while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    bus.in_ack    = '0;
    if (reset_n && grant_valid_s) begin
      bus.req_ready[grant_id_s] = 1'b1;
      if (in_range_s[grant_id_s]) begin
        bus.in_ack[index_s[grant_id_s]] = 1'b1;
      end else begin
        bus.in_ack = '0;
      end
    end else begin
      bus.req_ready = '0;
    end
  end

  // Next pointer and next response. Cycles without a grant produce an all-zero response.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    rsp_data_d  = '0;
    rsp_error_d = 1'b0;
    if (grant_valid_s) begin
      if (grant_id_s == LAST_REQ) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_id_s + REQ_ID_WIDTH'(1);
      end
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_id_s;
      rsp_error_d = !in_range_s[grant_id_s];
      if (in_range_s[grant_id_s]) begin
        rsp_data_d = bus.in[index_s[grant_id_s]*WORD_WIDTH +: WORD_WIDTH];
      end else begin
        rsp_data_d = '0;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Registers for the pointer and the response. A synchronous reset drops any in-flight response.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_error = rsp_error_q;

`ifdef MM_READ_ARBITER_STALL_COUNT_EN
  logic [15:0] stall_count_q, stall_count_d;

  // Count cycles with pending requests where none is eligible, saturating at 16'hFFFF.
  always_comb begin
    stall_count_d = stall_count_q;
    if ((|bus.req) && !grant_valid_s && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall_count = stall_count_q;
`else
  assign bus.stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mm_read_arbiter.sv
// Testbench for mm_read_arbiter. It applies a table of request vectors with
// hand-computed grants, then hand-written sequences for round-robin order,
// reset in the middle of traffic, and the stall counter. Expected responses
// are queued when a vector is driven and compared one cycle later.
module tb_mm_read_arbiter;
  localparam int WW = 36;
  localparam int AW = 10;

  localparam logic [AW-1:0] A0     = 10'd1020;
  localparam logic [AW-1:0] A1     = 10'd1021;
  localparam logic [AW-1:0] A2     = 10'd1022;
  localparam logic [AW-1:0] A3     = 10'd1023;
  localparam logic [AW-1:0] OOR_LO = 10'd1019;
  localparam logic [AW-1:0] OOR_WR = 10'd0;    // 1024 wraps to 0 in 10 bits
  localparam logic [AW-1:0] XA     = 10'd0;    // don't-care address (request low)

  localparam logic [WW-1:0] P0 = 36'h0000000AA;
  localparam logic [WW-1:0] P1 = 36'h0000000BB;
  localparam logic [WW-1:0] P2 = 36'h000000123;
  localparam logic [WW-1:0] P3 = 36'hF000000DD;

  typedef struct {
    logic [3:0]    req;
    logic [4*AW-1:0] addr;
    logic [3:0]    iv;
    logic [3:0]    exp_ready;
    logic [3:0]    exp_ack;
    logic [1:0]    exp_id;
    logic [WW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  typedef struct packed {
    logic          valid;
    logic [1:0]    id;
    logic [WW-1:0] data;
    logic          err;
  } rsp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  rsp_t sb[$];
  vec_t tbl[15];
  logic [WW-1:0] pdata[4];

  always #5 clock = ~clock;

  mm_read_arbiter_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .INPUT_COUNT(4),
                       .REQ_COUNT(4), .REQ_ID_WIDTH(2)) bus ();

  mm_read_arbiter #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .INPUT_COUNT(4),
                    .INPUT_BASE_ADDR(1020), .INPUT_ADDR_WIDTH(2),
                    .REQ_COUNT(4), .REQ_ID_WIDTH(2))
    dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  function automatic vec_t mk(logic [3:0] req, logic [AW-1:0] a0, logic [AW-1:0] a1,
                              logic [AW-1:0] a2, logic [AW-1:0] a3, logic [3:0] iv,
                              logic [3:0] rdy, logic [3:0] ack, logic [1:0] id,
                              logic [WW-1:0] data, logic err);
    vec_t v;
    v.req = req; v.addr = {a3, a2, a1, a0}; v.iv = iv;
    v.exp_ready = rdy; v.exp_ack = ack; v.exp_id = id; v.exp_data = data; v.exp_err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input string tag);
    rsp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(e.valid));
      check({tag, ".rsp_id"},    64'(bus.rsp_id),    64'(e.id));
      check({tag, ".rsp_data"},  64'(bus.rsp_data),  64'(e.data));
      check({tag, ".rsp_error"}, 64'(bus.rsp_error), 64'(e.err));
    end
  endtask

  // Drive one vector, check the same-cycle pulses, then check the registered response.
  task automatic apply(input vec_t v, input string tag);
    rsp_t e;
    @(negedge clock);
    bus.req      = v.req;
    bus.req_addr = v.addr;
    bus.in_valid = v.iv;
    #1;
    check({tag, ".req_ready"}, 64'(bus.req_ready), 64'(v.exp_ready));
    check({tag, ".in_ack"},    64'(bus.in_ack),    64'(v.exp_ack));
    e.valid = |v.exp_ready;
    e.id    = e.valid ? v.exp_id : 2'd0;
    e.data  = e.valid ? v.exp_data : 36'd0;
    e.err   = e.valid ? v.exp_err : 1'b0;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_rsp(tag);
  endtask

  initial begin
    pdata[0] = P0; pdata[1] = P1; pdata[2] = P2; pdata[3] = P3;
    // Columns: req, addr0..addr3, in_valid, ready, ack, id, data, err.
    tbl[0]  = mk(4'b0001, A2, XA, XA, XA, 4'b1111, 4'b0001, 4'b0100, 2'd0, P2, 1'b0);
    tbl[1]  = mk(4'b0010, XA, OOR_LO, XA, XA, 4'b1111, 4'b0010, 4'b0000, 2'd1, 36'd0, 1'b1);
    tbl[2]  = mk(4'b0010, XA, OOR_WR, XA, XA, 4'b1111, 4'b0010, 4'b0000, 2'd1, 36'd0, 1'b1);
    tbl[3]  = mk(4'b0000, XA, XA, XA, XA, 4'b1111, 4'b0000, 4'b0000, 2'd0, 36'd0, 1'b0);
    tbl[4]  = mk(4'b1111, A0, A1, A2, A3, 4'b1111, 4'b0100, 4'b0100, 2'd2, P2, 1'b0);
    tbl[5]  = mk(4'b1111, A0, A1, A2, A3, 4'b1111, 4'b1000, 4'b1000, 2'd3, P3, 1'b0);
    tbl[6]  = mk(4'b1111, A0, A1, A2, A3, 4'b1111, 4'b0001, 4'b0001, 2'd0, P0, 1'b0);
    tbl[7]  = mk(4'b1111, A0, A1, A2, A3, 4'b1111, 4'b0010, 4'b0010, 2'd1, P1, 1'b0);
    tbl[8]  = mk(4'b0011, A3, A0, XA, XA, 4'b0111, 4'b0010, 4'b0001, 2'd1, P0, 1'b0);
    tbl[9]  = mk(4'b0011, A3, A0, XA, XA, 4'b1111, 4'b0001, 4'b1000, 2'd0, P3, 1'b0);
    tbl[10] = mk(4'b0100, XA, XA, A1, XA, 4'b1101, 4'b0000, 4'b0000, 2'd0, 36'd0, 1'b0);
    tbl[11] = mk(4'b0101, OOR_LO, XA, A1, XA, 4'b0000, 4'b0001, 4'b0000, 2'd0, 36'd0, 1'b1);
    tbl[12] = mk(4'b0110, XA, A2, A2, XA, 4'b0100, 4'b0010, 4'b0100, 2'd1, P2, 1'b0);
    tbl[13] = mk(4'b0110, XA, A2, A2, XA, 4'b0100, 4'b0100, 4'b0100, 2'd2, P2, 1'b0);
    tbl[14] = mk(4'b1000, XA, XA, XA, A0, 4'b0001, 4'b1000, 4'b0001, 2'd3, P0, 1'b0);

    bus.in       = {P3, P2, P1, P0};
    bus.req      = 4'b0000;
    bus.req_addr = {A3, A2, A1, A0};
    bus.in_valid = 4'b1111;

    // Reset with everything eligible: no pulses, response registers cleared.
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      bus.req = 4'b1111;
      #1;
      check("rst.req_ready", 64'(bus.req_ready), 64'd0);
      check("rst.in_ack",    64'(bus.in_ack),    64'd0);
      @(posedge clock);
      #1;
      check("rst.rsp_valid",   64'(bus.rsp_valid),   64'd0);
      check("rst.rsp_id",      64'(bus.rsp_id),      64'd0);
      check("rst.rsp_data",    64'(bus.rsp_data),    64'd0);
      check("rst.rsp_error",   64'(bus.rsp_error),   64'd0);
      check("rst.stall_count", 64'(bus.stall_count), 64'd0);
    end
    @(negedge clock);
    bus.req = 4'b0000;
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Round-robin from pointer 0 with all requesters busy: ids 0,1,2,3,0 back to back.
    for (int k = 0; k < 5; k++) begin
      apply(mk(4'b1111, A0, A1, A2, A3, 4'b1111, 4'b0001 << (k % 4), 4'b0001 << (k % 4),
               2'(k % 4), pdata[k % 4], 1'b0), $sformatf("rr%0d", k));
    end

    // Reset in the cycle after a grant: the response is discarded and the pointer returns to 0.
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst.req_ready", 64'(bus.req_ready), 64'd0);
    check("midrst.in_ack",    64'(bus.in_ack),    64'd0);
    @(posedge clock);
    #1;
    check("midrst.rsp_valid",   64'(bus.rsp_valid),   64'd0);
    check("midrst.rsp_data",    64'(bus.rsp_data),    64'd0);
    check("midrst.stall_count", 64'(bus.stall_count), 64'd0);
    reset_n = 1'b1;
    apply(mk(4'b0110, A0, A1, A2, A3, 4'b1111, 4'b0010, 4'b0010, 2'd1, P1, 1'b0), "postrst");

    // Requester 2 waits on an empty port for five cycles.
    for (int k = 0; k < 5; k++) begin
      apply(mk(4'b0100, XA, XA, A1, XA, 4'b1101, 4'b0000, 4'b0000, 2'd0, 36'd0, 1'b0),
            $sformatf("stall%0d", k));
    end
`ifdef MM_READ_ARBITER_STALL_COUNT_EN
    check("stall.count5", 64'(bus.stall_count), 64'd5);
    repeat (65529) @(posedge clock);
    #1;
    check("stall.fffe", 64'(bus.stall_count), 64'hFFFE);
    @(posedge clock);
    #1;
    check("stall.ffff", 64'(bus.stall_count), 64'hFFFF);
    repeat (3) @(posedge clock);
    #1;
    check("stall.sat", 64'(bus.stall_count), 64'hFFFF);
`else
    check("stall.tied0", 64'(bus.stall_count), 64'd0);
`endif

    @(negedge clock);
    bus.req = 4'b0000;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
